// File: rtl/debug_pkg.sv
// Shared command codes and controller state encoding for the debug unit.
package debug_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_RESET = 8'h72;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_ADDR,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_WAIT,
    DONE
  } state_t;

  function automatic logic in_dump(input state_t s);
    return (s == DUMP_ADDR) || (s == DUMP_LOAD) || (s == DUMP_SEND) || (s == DUMP_WAIT);
  endfunction

endpackage

// File: rtl/dump_serializer.sv
// Holds one captured 32-bit word and presents it a byte at a time, MSB first.
module dump_serializer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        advance_i,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = '0;
    end else if (advance_i) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  always_comb begin
    byte_o = word_q[31:24];
    case (idx_q)
      2'd0:    byte_o = word_q[31:24];
      2'd1:    byte_o = word_q[23:16];
      2'd2:    byte_o = word_q[15:8];
      default: byte_o = word_q[7:0];
    endcase
  end

  assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/debug_unit_ctrl.sv
// UART-driven debug controller: run/step the datapath, then stream its debug
// words out over the transmitter.
module debug_unit_ctrl
  import debug_pkg::*;
#(
  parameter int DUMP_WORDS = 48,
  parameter int MAX_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic        cpu_halt,
  output logic        cpu_enable,
  output logic        cpu_reset,
  output logic [7:0]  dump_addr,
  input  logic [31:0] dump_data,
  output logic        led_idle,
  output logic        led_data_available,
  output logic        sent_flag,
  output logic [7:0]  send_counter
);

  localparam int              CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0]   CYC_LIMIT  = CW'(MAX_CYCLES);
  localparam logic [7:0]      LAST_ADDR  = 8'(DUMP_WORDS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          sent_q, sent_d;
  logic          cpu_rst_q, cpu_rst_d;

  logic       ser_load, ser_adv, ser_last;
  logic [7:0] ser_byte;

  dump_serializer u_ser (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (ser_load),
    .word_i    (dump_data),
    .advance_i (ser_adv),
    .byte_o    (ser_byte),
    .last_o    (ser_last)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sent_d     = sent_q;
    cpu_rst_d  = 1'b0;
    cpu_enable = 1'b0;
    tx_start   = 1'b0;
    ser_load   = 1'b0;
    ser_adv    = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (rx_done) begin
          case (rx_data)
            CMD_RUN:   begin state_d = RUN;  sent_d = 1'b0; end
            CMD_STEP:  begin state_d = STEP; sent_d = 1'b0; end
            CMD_RESET: begin cpu_rst_d = 1'b1; sent_d = 1'b0; end
            default:   ;
          endcase
        end
      end
      RUN: begin
        // Enable is combinational on cpu_halt so it drops in the exit cycle itself.
        if (cpu_halt || (cyc_q == CYC_LIMIT)) begin
          state_d = DUMP_ADDR;
          addr_d  = '0;
          cnt_d   = '0;
          sent_d  = 1'b0;
        end else begin
          cpu_enable = 1'b1;
          cyc_d      = cyc_q + 1'b1;
        end
      end
      STEP: begin
        cpu_enable = !cpu_halt;
        state_d    = DUMP_ADDR;
        addr_d     = '0;
        cnt_d      = '0;
        sent_d     = 1'b0;
      end
      DUMP_ADDR: state_d = DUMP_LOAD;
      DUMP_LOAD: begin
        ser_load = 1'b1;
        state_d  = DUMP_SEND;
      end
      DUMP_SEND: begin
        tx_start = 1'b1;
        state_d  = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (tx_done) begin
          cnt_d = cnt_q + 8'd1;
          if (!ser_last) begin
            ser_adv = 1'b1;
            state_d = DUMP_SEND;
          end else if (addr_q == LAST_ADDR) begin
            state_d = DONE;
            sent_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = DUMP_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      sent_q    <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      sent_q    <= sent_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign tx_data            = ser_byte;
  assign cpu_reset          = cpu_rst_q;
  assign dump_addr          = addr_q;
  assign send_counter       = cnt_q;
  assign sent_flag          = sent_q;
  assign led_idle           = (state_q == IDLE);
  assign led_data_available = in_dump(state_q);

endmodule
